imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//   Pipelined, parametrised immediate generator for the ID stage of the RV32I 5-stage CPU.
//   Takes a fetched instruction and its PC over a valid/ready handshake.
//   Classifies the format (I/S/B/U/J/NONE) and produces the sign-extended immediate.
//   Result passes through PIPE_DEPTH register stages, with stall and flush support.
// PARAMETERS
//   XLEN        32  datapath width for imm/pc/target; 32 or 64
//   PIPE_DEPTH  1   register stages between input and output; 1 or 2
// PORTS
//   clk         in   1     rising-edge clock
//   rst_n       in   1     asynchronous, active-low reset
//   flush       in   1     synchronous kill of all in-flight entries
//   in_valid    in   1     instr/pc valid
//   in_ready    out  1     stage can accept this cycle
//   instr       in   32    raw instruction word
//   pc          in   XLEN  PC of instr
//   out_valid   out  1     outputs valid
//   out_ready   in   1     consumer accepts this cycle
//   imm         out  XLEN  sign-extended immediate
//   imm_type    out  3     imm_type_e of entry
//   out_pc      out  XLEN  PC carried with entry
//   target      out  XLEN  pc+imm (only with IMM_TARGET_EN)
// BEHAVIOUR
//   - Reset (async, rst_n=0): all stage valid bits=0. out_valid=0. imm, out_pc, target=0. imm_type=IMM_NONE.
//   - Transfer occurs on a clk edge with valid&&ready high. Latency is PIPE_DEPTH cycles when unstalled.
//     Throughput is 1 per cycle.
//   - Per stage k: ready[k] = !valid[k] || ready[k+1]. Last stage uses ready[PIPE_DEPTH] = out_ready.
//     in_ready = ready[0]. The ready path is combinational back through all stages.
//   - Stall: while out_valid && !out_ready, every held output stays stable. Bubbles ahead of the stall still compress.
//   - Flush: at the next edge every valid bit is cleared. An input offered in the flush cycle is dropped.
//     Flush wins over any simultaneous in/out handshake. Data registers may keep stale values.
//   - Decode uses opcode = instr[6:0]:
//     0010011/0000011/1100111/1110011 -> I
//     0100011 -> S, 1100011 -> B, 0110111/0010111 -> U, 1101111 -> J, others -> NONE with imm=0.
//   - Immediate formats:
//     I = sext(instr[31:20])
//     S = sext({instr[31:25], instr[11:7]})
//     B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
//     U = sext({instr[31:12], 12'b0})   (sign-extended when XLEN=64)
//     J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
//   - Decode runs combinationally before stage 0. Later stages only carry data.
//   - Reset asserted mid-stream discards all entries immediately. The first input after rst_n rises is accepted normally.
// CONFIGURATION
//   IMM_TARGET_EN defined:
//     - target = out_pc + imm, modulo 2^XLEN (wraps, no overflow flag).
//     - The adder sits on the last stage's input side; latency is unchanged.
//   IMM_TARGET_EN undefined:
//     - The target port is still present and tied to 0.
//     - No adder is synthesised.
// STRUCTURE
//   - Package imm_gen_pkg:
//     - imm_type_e {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} (3 bits)
//     - opcode localparams OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL
//   - Sub-module imm_decode: combinational instr -> {imm_type, imm[XLEN-1:0]}.
//   - Top level holds the PIPE_DEPTH-deep register array, the handshake logic and the optional adder.
// TESTING (XLEN=32, PIPE_DEPTH=1 and 2, macro on and off)
//   - Load 0xFFF00093 (I, pc 0x0), out_ready=1
//     -> after PIPE_DEPTH cycles: imm=0xFFFFFFFF, imm_type=IMM_I.
//   - 0xFE112E23 (S) -> imm=0xFFFFFFFC, IMM_S.
//     0x123452B7 (U) -> imm=0x12345000, IMM_U.
//   - 0xFE000CE3 (B) at pc 0x00000100 -> imm=0xFFFFFFF8, target=0x000000F8 (0 without macro).
//     0x001000EF (J) at pc 0xFFFFF900 -> imm=0x00000800, target wraps to 0x00000100.
//   - Stream 4 back-to-back, hold out_ready=0 for 3 cycles
//     -> outputs stable, in_ready drops once all stages are full, no loss or reorder on release.
//   - Assert flush with 2 entries in flight and in_valid=1
//     -> out_valid=0 next cycle, the flushed entries never appear.
//   - Pull rst_n low between edges mid-stream -> out_valid=0 immediately.
//     0x00000033 (R-type) -> IMM_NONE, imm=0.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the RV32I immediate generator.
package imm_gen_pkg;

  // Immediate format of a decoded instruction
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Major opcodes (instr[6:0]) that carry an immediate
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder: instr -> {imm_type, sign-extended imm}.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic        [6:0]  w_opcode;
  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [20:0] w_imm_j;

  assign w_opcode = instr[6:0];
  assign w_imm_i  = instr[31:20];
  assign w_imm_s  = {instr[31:25], instr[11:7]};
  assign w_imm_b  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u  = {instr[31:12], 12'b0};
  assign w_imm_j  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Classify by opcode and sign-extend the matching field to XLEN
  always_comb begin
    imm_type = IMM_NONE;
    imm      = '0;
    unique case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm_type = IMM_I;
        imm      = XLEN'(w_imm_i);
      end
      OP_STORE: begin
        imm_type = IMM_S;
        imm      = XLEN'(w_imm_s);
      end
      OP_BRANCH: begin
        imm_type = IMM_B;
        imm      = XLEN'(w_imm_b);
      end
      OP_LUI, OP_AUIPC: begin
        imm_type = IMM_U;
        imm      = XLEN'(w_imm_u);
      end
      OP_JAL: begin
        imm_type = IMM_J;
        imm      = XLEN'(w_imm_j);
      end
      default: begin
        imm_type = IMM_NONE;
        imm      = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator for the ID stage.
// Decode happens ahead of stage 0; PIPE_DEPTH register stages follow with a
// valid/ready handshake, stall and flush.
// Optional feature: define IMM_TARGET_EN to produce target = out_pc + imm;
// otherwise target is tied to zero and no adder exists.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PIPE_DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] target
);

  localparam int unsigned LAST = PIPE_DEPTH - 1;

  imm_type_e       w_dec_type;
  logic [XLEN-1:0] w_dec_imm;

  logic [PIPE_DEPTH-1:0] r_valid;
  logic [XLEN-1:0]       r_imm  [PIPE_DEPTH];
  logic [XLEN-1:0]       r_pc   [PIPE_DEPTH];
  imm_type_e             r_type [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] w_ready;
  logic [PIPE_DEPTH-1:0] w_src_valid;
  logic [XLEN-1:0]       w_src_imm  [PIPE_DEPTH];
  logic [XLEN-1:0]       w_src_pc   [PIPE_DEPTH];
  imm_type_e             w_src_type [PIPE_DEPTH];

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr    (instr),
    .imm_type (w_dec_type),
    .imm      (w_dec_imm)
  );

  // Ready chain from the consumer back to the input; a running variable keeps
  // the chain free of self-reads on w_ready
  always_comb begin
    logic w_chain;
    w_chain = out_ready;
    w_ready = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      w_chain                   = !r_valid[PIPE_DEPTH-1-k] || w_chain;
      w_ready[PIPE_DEPTH-1-k]   = w_chain;
    end
  end

  assign in_ready = w_ready[0];

  // Source of each stage: decoder for stage 0, previous stage otherwise
  always_comb begin
    w_src_valid   = '0;
    w_src_valid[0] = in_valid;
    w_src_imm[0]  = w_dec_imm;
    w_src_pc[0]   = pc;
    w_src_type[0] = w_dec_type;
    for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_imm[k]   = r_imm[k-1];
      w_src_pc[k]    = r_pc[k-1];
      w_src_type[k]  = r_type[k-1];
    end
  end

  // Stage registers: advance where ready, data only on a valid source so a
  // stage that drains to a bubble keeps its last contents; flush clears valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        r_imm[k]  <= '0;
        r_pc[k]   <= '0;
        r_type[k] <= IMM_NONE;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_imm[k]  <= w_src_imm[k];
            r_pc[k]   <= w_src_pc[k];
            r_type[k] <= w_src_type[k];
          end
        end
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign imm       = r_imm[LAST];
  assign out_pc    = r_pc[LAST];
  assign imm_type  = r_type[LAST];

`ifdef IMM_TARGET_EN
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_target_sum;

  // Adder feeds the last stage so the target lines up with its entry
  assign w_target_sum = w_src_pc[LAST] + w_src_imm[LAST];

  // Target register follows the last-stage data load conditions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
    end else if (!flush && w_ready[LAST] && w_src_valid[LAST]) begin
      r_target <= w_target_sum;
    end
  end

  assign target = r_target;
`else
  assign target = '0;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage (XLEN=32).
// Build with -DIMM_TARGET_EN to exercise the target adder; PIPE_DEPTH may be overridden.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  parameter int unsigned PIPE_DEPTH = 1;
  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  imm_type_e       imm_type;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] target;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  ty;
  } exp_t;

  imm_gen_stage #(
    .XLEN       (XLEN),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .imm_type  (imm_type),
    .out_pc    (out_pc),
    .target    (target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] tgt(input logic [31:0] v);
`ifdef IMM_TARGET_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, then check the entry after PIPE_DEPTH edges
  task automatic send_one(input string tag, input logic [31:0] ins, input logic [31:0] p,
                          input logic [2:0] ty, input logic [31:0] ei, input logic [31:0] et);
    instr     = ins;
    pc        = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (PIPE_DEPTH - 1) tick();
    check({tag, ".valid"},  64'(out_valid), 64'(1'b1));
    check({tag, ".imm"},    64'(imm),       64'(ei));
    check({tag, ".type"},   64'(imm_type),  64'(ty));
    check({tag, ".pc"},     64'(out_pc),    64'(p));
    check({tag, ".target"}, 64'(target),    64'(tgt(et)));
    tick();
  endtask

  initial begin
    logic [31:0] vec_ins [4];
    logic [31:0] vec_imm [4];
    logic [2:0]  vec_ty  [4];
    exp_t        q[$];
    exp_t        e;
    int          sent;
    int          got;
    int          seen;
    bit          prev_stall;
    logic [31:0] held_imm;
    logic [31:0] held_pc;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    pc        = '0;

    // Reset state
    #12;
    check("rst.out_valid", 64'(out_valid), 64'(1'b0));
    check("rst.imm",       64'(imm),       64'h0);
    check("rst.type",      64'(imm_type),  64'(IMM_NONE));
    check("rst.out_pc",    64'(out_pc),    64'h0);
    check("rst.target",    64'(target),    64'h0);
    check("rst.in_ready",  64'(in_ready),  64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Formats, sign extension and target wrap
    send_one("I", 32'hFFF00093, 32'h0000_0000, IMM_I, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_one("S", 32'hFE112E23, 32'h0000_0040, IMM_S, 32'hFFFF_FFFC, 32'h0000_003C);
    send_one("U", 32'h123452B7, 32'h0000_0080, IMM_U, 32'h1234_5000, 32'h1234_5080);
    send_one("B", 32'hFE000CE3, 32'h0000_0100, IMM_B, 32'hFFFF_FFF8, 32'h0000_00F8);
    send_one("J", 32'h001000EF, 32'hFFFF_F900, IMM_J, 32'h0000_0800, 32'h0000_0100);

    // Back-to-back stream with a 3-cycle consumer stall
    vec_ins = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7, 32'h001000EF};
    vec_imm = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0800};
    vec_ty  = '{3'(IMM_I), 3'(IMM_S), 3'(IMM_U), 3'(IMM_J)};
    sent = 0;
    got  = 0;
    prev_stall = 1'b0;
    held_imm = '0;
    held_pc  = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = !(c >= 2 && c < 5);
      in_valid  = (sent < 4);
      instr     = (sent < 4) ? vec_ins[sent] : 32'h0;
      pc        = 32'h1000 + 32'(sent * 4);
      @(negedge clk);
      if (c == 4) check("stream.in_ready_full", 64'(in_ready), 64'(1'b0));
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          check("stall.imm_stable", 64'(imm),    64'(held_imm));
          check("stall.pc_stable",  64'(out_pc), 64'(held_pc));
        end
        held_imm   = imm;
        held_pc    = out_pc;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.imm = vec_imm[sent];
        e.pc  = pc;
        e.ty  = vec_ty[sent];
        q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream.unexpected_out", 64'(out_valid), 64'(1'b0));
        end else begin
          e = q.pop_front();
          check("stream.imm",  64'(imm),      64'(e.imm));
          check("stream.pc",   64'(out_pc),   64'(e.pc));
          check("stream.type", 64'(imm_type), 64'(e.ty));
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream.all_delivered", 64'(got), 64'(4));

    // Flush with the pipeline full and a new input offered
    out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !(out_valid && !in_ready); c++) begin
      in_valid = 1'b1;
      instr    = 32'h00500093;
      pc       = 32'h2000 + 32'(c * 4);
      tick();
    end
    check("flush.full_before", 64'(out_valid && !in_ready), 64'(1'b1));
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'h12300093;
    pc       = 32'h3000;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush.out_valid", 64'(out_valid), 64'(1'b0));
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
      tick();
    end
    check("flush.no_ghost_outputs", 64'(seen), 64'(0));
    send_one("post_flush", 32'h00A00093, 32'h0000_4000, IMM_I, 32'h0000_000A, 32'h0000_400A);

    // Asynchronous reset between edges with an entry held at the output
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF00093;
    pc        = 32'h5000;
    repeat (PIPE_DEPTH + 1) tick();
    in_valid = 1'b0;
    check("arst.valid_before", 64'(out_valid), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'(1'b0));
    check("arst.imm",       64'(imm),       64'h0);
    check("arst.type",      64'(imm_type),  64'(IMM_NONE));
    @(negedge clk);
    rst_n = 1'b1;

    // R-type after reset: no immediate
    send_one("R", 32'h00000033, 32'h0000_0200, IMM_NONE, 32'h0000_0000, 32'h0000_0200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
